sin_nco_ctrl: RTL and testbench
===============================

Name: sin_nco_ctrl

Overview:
Sequencer that drives the sine ROM as a numerically controlled oscillator.
- Keeps a phase accumulator and issues one ROM read per sample period.
- Holds the address stable through the ROM's full read latency, so the magnitude path and the delayed sign path are both valid at capture.
- Captures the sample and presents it with a one-cycle valid strobe.
- Sits between the system configuration logic and the ROM, which is a 2**A_WIDTH-entry magnitude table with the sign taken from the address MSB.

Parameters:
A_WIDTH, 16, ROM table address width; rom_addr is A_WIDTH+1 bits wide.
D_WIDTH, 16, ROM data width and sample width.
P_WIDTH, 24, phase accumulator width; must satisfy P_WIDTH >= A_WIDTH+1.
ROM_LAT, 2, cycles from ROM read issue to valid rom_data, sign bit included.
DIV, 8, sample period in clk cycles; must satisfy DIV >= ROM_LAT+2.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous reset, active-high.
start  in  1  one-cycle pulse; begins generation from phase 0.
stop  in  1  one-cycle pulse; finishes the in-flight sample, then idles.
cfg_valid  in  1  frequency word offered.
cfg_ready  out  1  frequency word can be accepted this cycle.
cfg_freq  in  P_WIDTH  phase increment per sample.
rom_addr  out  A_WIDTH+1  ROM address; MSB selects the sign half.
rom_re  out  1  ROM read enable.
rom_data  in  D_WIDTH  ROM output; sign in MSB, magnitude below.
sample  out  D_WIDTH  captured sample, sign-magnitude format.
sample_valid  out  1  one-cycle strobe: new sample on `sample`.
busy  out  1  high whenever state is not IDLE.

Behaviour:
- One clock, clk. Synchronous, active-high reset rst, sampled on the rising clk edge.
- Reset values: all outputs 0, state IDLE, phase 0, freq_reg 0, tick counter 0. The same applies when rst is asserted mid-operation; any in-flight sample is discarded with no sample_valid.
- States: IDLE, ISSUE, WAIT, CAPTURE, HOLD.
- IDLE:
  - start=1 and stop=0 -> ISSUE next cycle; phase cleared to 0.
  - stop alone is ignored.
  - start and stop in the same cycle: stop wins, remain IDLE.
- ISSUE (1 cycle):
  - rom_re=1, rom_addr=phase[P_WIDTH-1 -: A_WIDTH+1].
  - Tick counter reset to 1 (the ISSUE cycle counts as period cycle 0).
  - -> WAIT.
- WAIT:
  - rom_addr held at the ISSUE value; rom_re=1.
  - Lasts ROM_LAT-1 cycles, then -> CAPTURE.
  - If ROM_LAT=1, WAIT is skipped.
- CAPTURE (1 cycle):
  - Entered exactly ROM_LAT cycles after ISSUE; rom_addr still held.
  - sample <= rom_data; sample_valid=1 on the following cycle.
  - phase <= phase + freq_reg, modulo 2**P_WIDTH; wrap is silent.
  - -> HOLD.
- HOLD:
  - rom_re=0; rom_addr keeps its last value.
  - Tick counter increments each cycle.
  - When the counter reaches DIV-1 -> ISSUE, unless a stop is pending, in which case -> IDLE.
- Timing:
  - ISSUE-to-ISSUE spacing is exactly DIV cycles.
  - sample_valid rises ROM_LAT+1 cycles after the ISSUE cycle.
  - First sample_valid comes ROM_LAT+2 cycles after the start pulse.
- stop outside IDLE:
  - Sets stop_pending.
  - The current sample still completes with sample_valid.
  - The FSM then enters IDLE from HOLD at the period boundary.
  - stop_pending is cleared on entering IDLE.
- sample keeps its last value in IDLE; it is never cleared except by rst.
- Configuration handshake:
  - cfg_ready=1 in every state except CAPTURE.
  - A transfer occurs when cfg_valid and cfg_ready are both 1; freq_reg <= cfg_freq.
  - A new word first affects the next CAPTURE accumulate.
  - Offers in the CAPTURE cycle are stalled, not dropped; the source holds cfg_valid.
- rom_re is never asserted in IDLE or HOLD.

Optional Feature:
SIN_NCO_PHASE_OFS_EN.
- Defined:
  - Adds input cfg_phase [P_WIDTH-1:0], latched in the same cfg handshake as cfg_freq.
  - ISSUE address becomes (phase + phase_ofs_reg)[P_WIDTH-1 -: A_WIDTH+1], addition modulo 2**P_WIDTH.
  - phase_ofs_reg resets to 0.
- Not defined: the port is absent and the address comes from phase alone.

Test Plan:
1. Reset mid-WAIT: rst high during WAIT -> next cycle busy=0, rom_re=0, rom_addr=0, sample=0, sample_valid=0. No later sample_valid until the next start.
2. Steady run: defaults, cfg_freq=0x000100, start -> rom_addr sequence 0, 2, 4, 6 on successive ISSUE cycles spaced 8 cycles apart. sample_valid comes 3 cycles after each ISSUE, and sample equals the ROM model word for that address.
3. Wrap and sign: cfg_freq=0x400000 -> addresses 0x00000, 0x08000, 0x10000, 0x18000, 0x00000. Samples from the 0x1xxxx addresses carry MSB=1.
4. start and stop in the same cycle while IDLE -> stays IDLE, busy=0, no rom_re. A stop issued in WAIT -> exactly one further sample_valid, then busy=0 at the period boundary.
5. cfg offered in the CAPTURE cycle: cfg_ready=0 for that cycle; the transfer completes the next cycle. The new increment is first visible at the CAPTURE after next.
6. With SIN_NCO_PHASE_OFS_EN defined: cfg_phase=0x800000, cfg_freq=0 -> every ISSUE drives rom_addr=0x10000.

Source files
------------

// File: rtl/sin_nco_ctrl.sv
// Sine-ROM NCO sequencer: phase accumulator, one ROM read per DIV-cycle period, captured sample + valid strobe.
// Build option SIN_NCO_PHASE_OFS_EN adds a cfg_phase offset applied to every ISSUE address.
//
// state   | meaning
// IDLE    | not generating; sample holds its last value
// ISSUE   | read issued at the current phase (period cycle 0)
// WAIT    | address held while the ROM read is in flight
// CAPTURE | rom_data valid; sample captured, phase accumulated
// HOLD    | pad out the rest of the sample period
module sin_nco_ctrl #(
    parameter int A_WIDTH = 16,
    parameter int D_WIDTH = 16,
    parameter int P_WIDTH = 24,
    parameter int ROM_LAT = 2,
    parameter int DIV     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               cfg_valid,
    output logic               cfg_ready,
`ifdef SIN_NCO_PHASE_OFS_EN
    input  logic [P_WIDTH-1:0] cfg_phase,
`endif
    input  logic [P_WIDTH-1:0] cfg_freq,
    output logic [A_WIDTH:0]   rom_addr,
    output logic               rom_re,
    input  logic [D_WIDTH-1:0] rom_data,
    output logic [D_WIDTH-1:0] sample,
    output logic               sample_valid,
    output logic               busy
);

    localparam int ADDR_W = A_WIDTH + 1;
    localparam int T_W    = $clog2(DIV + 1);

    localparam logic [T_W-1:0] TICK_ONE     = T_W'(1);
    localparam logic [T_W-1:0] TICK_RD_DONE = T_W'(ROM_LAT - 1);
    localparam logic [T_W-1:0] TICK_LAST    = T_W'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        HOLD    = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [P_WIDTH-1:0]  phase;
    logic [P_WIDTH-1:0]  freq_reg;
    logic [T_W-1:0]      tick;
    logic                stop_pending;
    logic [ADDR_W-1:0]   addr_hold;
    logic [ADDR_W-1:0]   issue_addr;
    logic                cfg_xfer;

`ifdef SIN_NCO_PHASE_OFS_EN
    logic [P_WIDTH-1:0]  phase_ofs_reg;

    // Offset is added at full phase precision so carries from the low bits reach the address.
    always_comb begin
        issue_addr = ADDR_W'((phase + phase_ofs_reg) >> (P_WIDTH - ADDR_W));
    end
`else
    always_comb begin
        issue_addr = phase[P_WIDTH-1 -: ADDR_W];
    end
`endif

    assign cfg_xfer = cfg_valid && cfg_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b1;
        rom_re    = 1'b0;
        busy      = 1'b1;
        rom_addr  = addr_hold;

        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start && !stop) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                rom_re   = 1'b1;
                rom_addr = issue_addr;
                state_nxt = (ROM_LAT == 1) ? CAPTURE : WAIT;
            end
            WAIT: begin
                rom_re = 1'b1;
                if (tick == TICK_RD_DONE) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                // freq_reg is being consumed this cycle, so new words wait one cycle.
                cfg_ready = 1'b0;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (tick == TICK_LAST) begin
                    state_nxt = (stop_pending || stop) ? IDLE : ISSUE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase        <= '0;
            freq_reg     <= '0;
            tick         <= '0;
            stop_pending <= 1'b0;
            addr_hold    <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;

            if (cfg_xfer) begin
                freq_reg <= cfg_freq;
            end

            if (state_nxt == IDLE) begin
                stop_pending <= 1'b0;
            end else if (stop && state != IDLE) begin
                stop_pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    tick <= '0;
                    if (start && !stop) begin
                        phase <= '0;
                    end
                end
                ISSUE: begin
                    // The ISSUE cycle is period cycle 0, so the next cycle is 1.
                    tick      <= TICK_ONE;
                    addr_hold <= issue_addr;
                end
                WAIT: begin
                    tick <= tick + TICK_ONE;
                end
                CAPTURE: begin
                    tick         <= tick + TICK_ONE;
                    sample       <= rom_data;
                    sample_valid <= 1'b1;
                    phase        <= phase + freq_reg;
                end
                HOLD: begin
                    tick <= tick + TICK_ONE;
                end
                default: begin
                    tick <= '0;
                end
            endcase
        end
    end

`ifdef SIN_NCO_PHASE_OFS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_ofs_reg <= '0;
        end else if (cfg_xfer) begin
            phase_ofs_reg <= cfg_phase;
        end
    end
`endif

endmodule

// File: tb/tb_sin_nco_ctrl.sv
// Bench for sin_nco_ctrl: behavioural ROM with read latency, event monitor, and an arithmetic phase/timing model.
// Covers the SIN_NCO_PHASE_OFS_EN build when that macro is defined.
module tb_sin_nco_ctrl;

    localparam int A_WIDTH = 16;
    localparam int D_WIDTH = 16;
    localparam int P_WIDTH = 24;
    localparam int ROM_LAT = 2;
    localparam int DIV     = 8;
    localparam int ADDR_W  = A_WIDTH + 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               stop;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [P_WIDTH-1:0] cfg_freq;
`ifdef SIN_NCO_PHASE_OFS_EN
    logic [P_WIDTH-1:0] cfg_phase;
`endif
    logic [ADDR_W-1:0]  rom_addr;
    logic               rom_re;
    logic [D_WIDTH-1:0] rom_data;
    logic [D_WIDTH-1:0] sample;
    logic               sample_valid;
    logic               busy;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [P_WIDTH-1:0] ofs_model = '0;

    sin_nco_ctrl #(
        .A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH), .P_WIDTH(P_WIDTH),
        .ROM_LAT(ROM_LAT), .DIV(DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stop(stop),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
`ifdef SIN_NCO_PHASE_OFS_EN
        .cfg_phase(cfg_phase),
`endif
        .cfg_freq(cfg_freq),
        .rom_addr(rom_addr),
        .rom_re(rom_re),
        .rom_data(rom_data),
        .sample(sample),
        .sample_valid(sample_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Table contents: sign from the address MSB, a scrambled magnitude below it.
    function automatic logic [D_WIDTH-1:0] rom_word(input logic [ADDR_W-1:0] a);
        logic [D_WIDTH-2:0] m;
        m = (D_WIDTH-1)'(a[A_WIDTH-1:0] * 16'd40503 + 16'd7);
        return {a[A_WIDTH], m};
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input longint unsigned ph);
        longint unsigned p;
        p = (ph + 64'(ofs_model)) % (64'd1 << P_WIDTH);
        return ADDR_W'(p >> (P_WIDTH - ADDR_W));
    endfunction

    function automatic logic [ADDR_W-1:0] exp_addr(input int j, input logic [P_WIDTH-1:0] freq);
        return addr_of(64'(j) * 64'(freq));
    endfunction

    logic [D_WIDTH-1:0] rom_pipe [ROM_LAT];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROM_LAT; i++) rom_pipe[i] <= '0;
        end else if (rom_re) begin
            rom_pipe[0] <= rom_word(rom_addr);
            for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
        end
    end
    assign rom_data = rom_pipe[ROM_LAT-1];

    // Event log: issue cycles/addresses, strobes, rom_re cycles, address stability.
    int                iss_cyc [$];
    logic [ADDR_W-1:0] iss_addr [$];
    int                sv_cyc [$];
    logic [D_WIDTH-1:0] sv_data [$];
    int                re_cnt   = 0;
    int                hold_err = 0;
    int                idle_cyc = 0;
    logic              prev_re   = 1'b0;
    logic              prev_busy = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;

    always @(negedge clk) begin
        if (rom_re && !prev_re) begin
            iss_cyc.push_back(cyc);
            iss_addr.push_back(rom_addr);
        end else if (busy && prev_busy && rom_addr !== prev_addr) begin
            hold_err <= hold_err + 1;
        end
        if (rom_re) re_cnt <= re_cnt + 1;
        if (sample_valid) begin
            sv_cyc.push_back(cyc);
            sv_data.push_back(sample);
        end
        if (prev_busy && !busy) idle_cyc <= cyc;
        prev_re   <= rom_re;
        prev_busy <= busy;
        prev_addr <= rom_addr;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic configure(input logic [P_WIDTH-1:0] freq, input logic [P_WIDTH-1:0] ofs);
        @(negedge clk);
        cfg_valid = 1'b1;
        cfg_freq  = freq;
`ifdef SIN_NCO_PHASE_OFS_EN
        cfg_phase = ofs;
`endif
        check("cfg_ready_idle", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        cfg_valid = 1'b0;
        ofs_model = ofs;
    endtask

    // Start, stop stop_off cycles after the start pulse, then compare every logged event to the model.
    task automatic run(input logic [P_WIDTH-1:0] freq, input logic [P_WIDTH-1:0] ofs,
                       input int stop_off, input string tag);
        int t0, n, bi, bs, br, bh;
        configure(freq, ofs);
        bi = iss_cyc.size();
        bs = sv_cyc.size();
        br = re_cnt;
        bh = hold_err;
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        repeat (stop_off - 1) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        for (int i = 0; i < 3 * DIV && busy; i++) @(negedge clk);
        repeat (DIV) @(negedge clk);
        n = (stop_off - 1) / DIV + 1;
        check($sformatf("%s_busy_end", tag), 32'(busy), 32'd0);
        check($sformatf("%s_n_issue", tag), 32'(iss_cyc.size() - bi), 32'(n));
        check($sformatf("%s_n_valid", tag), 32'(sv_cyc.size() - bs), 32'(n));
        check($sformatf("%s_re_cycles", tag), 32'(re_cnt - br), 32'(ROM_LAT * n));
        check($sformatf("%s_addr_hold", tag), 32'(hold_err - bh), 32'd0);
        check($sformatf("%s_idle_cyc", tag), 32'(idle_cyc - t0), 32'(1 + n * DIV));
        for (int j = 0; j < n; j++) begin
            if (bi + j < iss_cyc.size()) begin
                check($sformatf("%s_iss_cyc[%0d]", tag, j), 32'(iss_cyc[bi+j] - t0), 32'(1 + j * DIV));
                check($sformatf("%s_addr[%0d]", tag, j), 32'(iss_addr[bi+j]), 32'(exp_addr(j, freq)));
            end
            if (bs + j < sv_cyc.size()) begin
                check($sformatf("%s_sv_cyc[%0d]", tag, j), 32'(sv_cyc[bs+j] - t0), 32'(ROM_LAT + 2 + j * DIV));
                check($sformatf("%s_sample[%0d]", tag, j), 32'(sv_data[bs+j]), 32'(rom_word(exp_addr(j, freq))));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, bi, bs;
        logic [P_WIDTH-1:0] f1, f2;
        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        cfg_valid = 1'b0;
        cfg_freq  = '0;
`ifdef SIN_NCO_PHASE_OFS_EN
        cfg_phase = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rom_re", 32'(rom_re), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_sample", 32'(sample), 32'd0);
        check("rst_sample_valid", 32'(sample_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_cfg_ready", 32'(cfg_ready), 32'd1);

        // Steady run: addresses 0,2,4,6.
        run(24'h000100, 24'h0, 1 + 3 * DIV + 1, "steady");
        // Wrap and sign: stop lands in WAIT of the fifth period.
        run(24'h400000, 24'h0, 1 + 4 * DIV + 1, "wrap");

        // Reset during WAIT of the second sample.
        configure(24'h000100, 24'h0);
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        repeat (DIV + 1) @(negedge clk);
        check("prerst_rom_re", 32'(rom_re), 32'd1);
        check("prerst_rom_addr", 32'(rom_addr), 32'h2);
        check("prerst_sample", 32'(sample), 32'(rom_word(17'h0)));
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_rom_re", 32'(rom_re), 32'd0);
        check("midrst_rom_addr", 32'(rom_addr), 32'd0);
        check("midrst_sample", 32'(sample), 32'd0);
        check("midrst_sample_valid", 32'(sample_valid), 32'd0);
        rst = 1'b0;
        bs = sv_cyc.size();
        bi = iss_cyc.size();
        repeat (3 * DIV) @(negedge clk);
        check("postrst_no_valid", 32'(sv_cyc.size() - bs), 32'd0);
        check("postrst_no_issue", 32'(iss_cyc.size() - bi), 32'd0);

        // start+stop together, then stop alone, while IDLE.
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("startstop_busy[%0d]", i), 32'(busy), 32'd0);
            check($sformatf("startstop_rom_re[%0d]", i), 32'(rom_re), 32'd0);
            @(negedge clk);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_alone_busy", 32'(busy), 32'd0);

        // cfg offered during CAPTURE is stalled one cycle and used from the CAPTURE after next.
        f1 = 24'($urandom);
        f2 = 24'($urandom);
        configure(f1, 24'h0);
        bi = iss_cyc.size();
        bs = sv_cyc.size();
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        repeat (ROM_LAT) @(negedge clk);
        cfg_valid = 1'b1;
        cfg_freq  = f2;
        check("cfg_ready_capture", 32'(cfg_ready), 32'd0);
        @(negedge clk);
        check("cfg_ready_after", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        cfg_valid = 1'b0;
        repeat (2 * DIV - ROM_LAT - 1) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        for (int i = 0; i < 3 * DIV && busy; i++) @(negedge clk);
        check("cfg_n_issue", 32'(iss_cyc.size() - bi), 32'd3);
        if (iss_cyc.size() - bi >= 3) begin
            check("cfg_addr1", 32'(iss_addr[bi+1]), 32'(addr_of(64'(f1))));
            check("cfg_addr2", 32'(iss_addr[bi+2]), 32'(addr_of(64'(f1) + 64'(f2))));
        end
        if (sv_cyc.size() - bs >= 3) begin
            check("cfg_sample2", 32'(sv_data[bs+2]), 32'(rom_word(addr_of(64'(f1) + 64'(f2)))));
        end

        // Randomised frequencies and stop points.
        for (int r = 0; r < 4; r++) begin
            run(24'($urandom), 24'h0, int'($urandom_range(1, 4 * DIV)), $sformatf("rand%0d", r));
        end

`ifdef SIN_NCO_PHASE_OFS_EN
        run(24'h000000, 24'h800000, 1 + 2 * DIV + 3, "ofs");
        run(24'($urandom), 24'($urandom), int'($urandom_range(1, 3 * DIV)), "ofs_rand");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
